// File: rtl/tqvp_vga_capture_pkg.sv
// Shared definitions for the VGA line grabber: FSM states, register map, pin and bit positions.
// The optional sync-polarity feature is selected with VGA_CAPTURE_SYNC_POL_EN.
package tqvp_vga_capture_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_VS   = 3'd1,
    S_WAIT_LINE = 3'd2,
    S_WAIT_HOFF = 3'd3,
    S_SAMPLE    = 3'd4
  } state_t;

  localparam logic [5:0] ADDR_CTRL = 6'h30;
  localparam logic [5:0] ADDR_LINE = 6'h34;
  localparam logic [5:0] ADDR_HOFF = 6'h38;
  localparam logic [5:0] ADDR_DIV  = 6'h3C;

  localparam int PIN_PIXEL = 0;
  localparam int PIN_HSYNC = 1;
  localparam int PIN_VSYNC = 2;

  localparam int CTRL_ARM     = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_IRQ_ACK = 2;
  localparam int CTRL_HPOL    = 4;
  localparam int CTRL_VPOL    = 5;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_SHORT   = 2;
  localparam int STAT_CNT_LSB = 8;

endpackage

// File: rtl/tqvp_rejunity_vga_capture_if.sv
// TinyQV peripheral bus between the CPU (master) and the line grabber (slave).
// Part of the VGA capture slice; see the top file for the VGA_CAPTURE_SYNC_POL_EN option.
interface tqvp_rejunity_vga_capture_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready
  );
endinterface

// File: rtl/vga_capture_edge.sv
// Sync edge detector: normalises polarity to "active", then strobes leading/trailing edges
// one cycle wide against a delayed copy. Polarity input is driven by VGA_CAPTURE_SYNC_POL_EN logic in the top.
module vga_capture_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  input  logic i_pol,
  output logic o_lead,
  output logic o_trail
);

  logic w_active;
  logic r_active_d;

  assign w_active = i_pol ? i_sig : ~i_sig;

  always_ff @(posedge clk) begin
    if (rst) r_active_d <= 1'b0;
    else     r_active_d <= w_active;
  end

  assign o_lead  = w_active & ~r_active_d;
  assign o_trail = ~w_active & r_active_d;

endmodule

// File: rtl/tqvp_rejunity_vga_capture.sv
// VGA line grabber: captures PIXEL_COUNT mono samples from one scanline for the CPU to read.
// Define VGA_CAPTURE_SYNC_POL_EN to make hsync/vsync polarity programmable via CTRL b4/b5.
//
// state       | meaning
// S_IDLE      | not armed; buffer and status hold
// S_WAIT_VS   | armed, waiting for vsync trailing edge
// S_WAIT_LINE | counting hsync trailing edges up to LINE
// S_WAIT_HOFF | counting HOFF clocks into the target line
// S_SAMPLE    | storing one pixel every DIV+1 clocks
module tqvp_rejunity_vga_capture
  import tqvp_vga_capture_pkg::*;
#(
  parameter int PIXEL_COUNT = 320,
  parameter int LINE_W      = 10,
  parameter int HOFF_W      = 11,
  parameter int DIV_W       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    ui_in,
  output logic [7:0]                    uo_out,
  tqvp_rejunity_vga_capture_if.slave    bus,
  output logic                          user_interrupt
);

  localparam int IDX_W  = $clog2(PIXEL_COUNT + 1);
  localparam int NWORDS = PIXEL_COUNT / 32;

  state_t r_state, w_state_nxt;
  logic [LINE_W-1:0] r_line_cnt, w_line_nxt, r_cfg_line;
  logic [HOFF_W-1:0] r_hoff_cnt, w_hoff_nxt, r_cfg_hoff;
  logic [DIV_W-1:0]  r_div_cnt,  w_div_nxt,  r_cfg_div;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic r_done, w_done_nxt, r_short, w_short_nxt, r_irq, w_irq_nxt;
  logic w_sample_en;
  logic [PIXEL_COUNT-1:0] r_buf;

  logic w_wr, w_wr_ctrl, w_arm, w_abort, w_ack;
  logic w_hpol, w_vpol;
  logic w_hs_lead, w_hs_trail, w_vs_lead, w_vs_trail;
  logic [31:0] w_status, w_rdata;
  logic w_unused_ok;

  assign w_wr      = (bus.data_write_n != 2'b11);
  assign w_wr_ctrl = w_wr && (bus.address[5:2] == ADDR_CTRL[5:2]);
  assign w_abort   = w_wr_ctrl & bus.data_in[CTRL_ABORT];
  assign w_arm     = w_wr_ctrl & bus.data_in[CTRL_ARM] & ~bus.data_in[CTRL_ABORT];
  assign w_ack     = w_wr_ctrl & bus.data_in[CTRL_IRQ_ACK];

`ifdef VGA_CAPTURE_SYNC_POL_EN
  logic r_hpol, r_vpol;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hpol <= 1'b0;
      r_vpol <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_hpol <= bus.data_in[CTRL_HPOL];
      r_vpol <= bus.data_in[CTRL_VPOL];
    end
  end
  assign w_hpol = r_hpol;
  assign w_vpol = r_vpol;
`else
  assign w_hpol = 1'b0;
  assign w_vpol = 1'b0;
`endif

  vga_capture_edge u_hs_edge (
    .clk     (clk),
    .rst     (rst),
    .i_sig   (ui_in[PIN_HSYNC]),
    .i_pol   (w_hpol),
    .o_lead  (w_hs_lead),
    .o_trail (w_hs_trail)
  );

  vga_capture_edge u_vs_edge (
    .clk     (clk),
    .rst     (rst),
    .i_sig   (ui_in[PIN_VSYNC]),
    .i_pol   (w_vpol),
    .o_lead  (w_vs_lead),
    .o_trail (w_vs_trail)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_line_cnt <= '0;
      r_hoff_cnt <= '0;
      r_div_cnt  <= '0;
      r_idx      <= '0;
      r_done     <= 1'b0;
      r_short    <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_line_cnt <= w_line_nxt;
      r_hoff_cnt <= w_hoff_nxt;
      r_div_cnt  <= w_div_nxt;
      r_idx      <= w_idx_nxt;
      r_done     <= w_done_nxt;
      r_short    <= w_short_nxt;
      r_irq      <= w_irq_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_line_nxt  = r_line_cnt;
    w_hoff_nxt  = r_hoff_cnt;
    w_div_nxt   = r_div_cnt;
    w_idx_nxt   = r_idx;
    w_done_nxt  = r_done;
    w_short_nxt = r_short;
    w_irq_nxt   = w_ack ? 1'b0 : r_irq;
    w_sample_en = 1'b0;

    unique case (r_state)
      S_WAIT_VS: begin
        if (w_vs_trail) begin
          w_line_nxt  = '0;
          w_state_nxt = S_WAIT_LINE;
        end
      end
      S_WAIT_LINE: begin
        if (w_vs_trail) begin
          w_line_nxt = '0;
        end else if (w_hs_trail) begin
          if (r_line_cnt == r_cfg_line) begin
            w_hoff_nxt  = '0;
            w_state_nxt = S_WAIT_HOFF;
          end else if (r_line_cnt != '1) begin
            w_line_nxt = r_line_cnt + 1'b1;
          end
        end
      end
      S_WAIT_HOFF: begin
        if (r_hoff_cnt == r_cfg_hoff) begin
          w_idx_nxt   = '0;
          w_div_nxt   = '0;
          w_state_nxt = S_SAMPLE;
        end else begin
          w_hoff_nxt = r_hoff_cnt + 1'b1;
        end
      end
      S_SAMPLE: begin
        // A new line starting wins over a sample due in the same cycle.
        if (w_hs_lead) begin
          w_short_nxt = 1'b1;
          w_done_nxt  = 1'b1;
          w_irq_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_div_cnt == '0) begin
          w_sample_en = 1'b1;
          w_idx_nxt   = r_idx + 1'b1;
          w_div_nxt   = r_cfg_div;
          if (r_idx == IDX_W'(PIXEL_COUNT - 1)) begin
            w_done_nxt  = 1'b1;
            w_irq_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_div_nxt = r_div_cnt - 1'b1;
        end
      end
      default: ;
    endcase

    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_done_nxt  = r_done;
      w_short_nxt = r_short;
      w_irq_nxt   = w_ack ? 1'b0 : r_irq;
      w_idx_nxt   = r_idx;
      w_sample_en = 1'b0;
    end else if (w_arm) begin
      w_state_nxt = S_WAIT_VS;
      w_done_nxt  = 1'b0;
      w_short_nxt = 1'b0;
      w_irq_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_line <= '0;
      r_cfg_hoff <= '0;
      r_cfg_div  <= '0;
    end else if (w_wr) begin
      if (bus.address[5:2] == ADDR_LINE[5:2]) r_cfg_line <= bus.data_in[LINE_W-1:0];
      if (bus.address[5:2] == ADDR_HOFF[5:2]) r_cfg_hoff <= bus.data_in[HOFF_W-1:0];
      if (bus.address[5:2] == ADDR_DIV[5:2])  r_cfg_div  <= bus.data_in[DIV_W-1:0];
    end
  end

  // Capture buffer is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_sample_en && !rst) r_buf[r_idx] <= ui_in[PIN_PIXEL];
  end

  always_comb begin
    w_status = '0;
    w_status[STAT_BUSY]  = (r_state != S_IDLE);
    w_status[STAT_DONE]  = r_done;
    w_status[STAT_SHORT] = r_short;
    w_status[CTRL_HPOL]  = w_hpol;
    w_status[CTRL_VPOL]  = w_vpol;
    w_status[STAT_CNT_LSB +: 7] = 7'(r_idx >> 5);
  end

  always_comb begin
    w_rdata = '0;
    for (int w = 0; w < NWORDS; w++) begin
      if (bus.address[5:2] == 4'(w)) w_rdata = r_buf[w*32 +: 32];
    end
    if (bus.address[5:2] == ADDR_CTRL[5:2]) w_rdata = w_status;
    if (bus.address[5:2] == ADDR_LINE[5:2]) w_rdata = 32'(r_cfg_line);
    if (bus.address[5:2] == ADDR_HOFF[5:2]) w_rdata = 32'(r_cfg_hoff);
    if (bus.address[5:2] == ADDR_DIV[5:2])  w_rdata = 32'(r_cfg_div);
  end

  assign bus.data_out   = w_rdata;
  assign bus.data_ready = 1'b1;
  assign uo_out         = 8'h00;
  assign user_interrupt = r_irq;

  assign w_unused_ok = ^{ui_in[7:3], bus.data_read_n, bus.data_in[31:HOFF_W],
                         bus.address[1:0], w_hs_trail & 1'b0, w_vs_lead};

endmodule

// File: tb/tb_tqvp_rejunity_vga_capture.sv
// Self-checking bench for the VGA line grabber: random frames checked against a sample-time model.
// Build with VGA_CAPTURE_SYNC_POL_EN to also exercise active-high syncs.
module tb_tqvp_rejunity_vga_capture;
  localparam int PIXEL  = 320;
  localparam int NWORDS = PIXEL / 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] ui_in, uo_out;
  logic user_interrupt;
  logic hs_act = 1'b0, vs_act = 1'b0, pix = 1'b0;
  logic hpol = 1'b0, vpol = 1'b0;
  int checks = 0, failures = 0;
  logic line_pix [0:4095];
  logic model_buf [0:PIXEL-1];
  int cur_line, cur_hoff, cur_div, irq_off;
  logic [1:0]  exp_pol = 2'b00;
  logic [31:0] ctrl_pol = 32'h0;

  tqvp_rejunity_vga_capture_if bus_if();

  assign ui_in = {5'b0, (vpol ? vs_act : ~vs_act), (hpol ? hs_act : ~hs_act), pix};

  tqvp_rejunity_vga_capture dut (
    .clk            (clk),
    .rst            (rst),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .bus            (bus_if),
    .user_interrupt (user_interrupt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    bus_if.address      = a;
    bus_if.data_in      = d;
    bus_if.data_write_n = 2'b10;
    tick();
    bus_if.data_write_n = 2'b11;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    bus_if.address     = a;
    bus_if.data_read_n = 2'b10;
    #1;
    d = bus_if.data_out;
    bus_if.data_read_n = 2'b11;
  endtask

  task automatic setup(input int l, input int h, input int dv);
    cur_line = l; cur_hoff = h; cur_div = dv;
    bus_write(6'h34, 32'(l));
    bus_write(6'h38, 32'(h));
    bus_write(6'h3C, 32'(dv));
  endtask

  task automatic rand_pixels();
    for (int o = 0; o < 4096; o++) line_pix[o] = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_vsync();
    hs_act = 1'b0; pix = 1'b0; vs_act = 1'b1;
    repeat (3) tick();
    vs_act = 1'b0;
    repeat (2) tick();
  endtask

  // Active region offset 0 is the cycle in which hsync is released.
  task automatic drive_line(input int act_len, input bit target, input int ack_at);
    hs_act = 1'b1; pix = 1'b0;
    repeat (4) tick();
    hs_act = 1'b0;
    for (int o = 0; o < act_len; o++) begin
      pix = target ? line_pix[o] : ~line_pix[o];
      if (o == ack_at) begin
        bus_if.address      = 6'h30;
        bus_if.data_in      = 32'h4 | ctrl_pol;
        bus_if.data_write_n = 2'b10;
      end
      tick();
      if (o == ack_at) bus_if.data_write_n = 2'b11;
      if (target && irq_off < 0 && user_interrupt === 1'b1) irq_off = o;
    end
  endtask

  task automatic capture_frame(input int act_len, input bit restart, input int ack_at);
    bus_write(6'h30, 32'h1 | ctrl_pol);
    irq_off = -1;
    drive_vsync();
    if (restart) begin
      drive_line(act_len, 1'b0, -1);
      drive_vsync();
    end
    for (int l = 0; l < cur_line; l++) drive_line(act_len, 1'b0, -1);
    drive_line(act_len, 1'b1, ack_at);
    drive_line(20, 1'b0, -1);
    repeat (3) tick();
  endtask

  // Sample i is taken HOFF+2+i*(DIV+1) clocks after the target hsync release, if the line is still active.
  function automatic int model_capture(input int act_len);
    int n = 0;
    for (int i = 0; i < PIXEL; i++) begin
      int off = cur_hoff + 2 + i * (cur_div + 1);
      if (off < act_len) begin
        model_buf[i] = line_pix[off];
        n++;
      end
    end
    return n;
  endfunction

  function automatic int full_len();
    return cur_hoff + 2 + PIXEL * (cur_div + 1) + int'($urandom_range(0, 4));
  endfunction

  task automatic check_capture(input string name, input int n);
    logic [31:0] d, e;
    e = {17'b0, 7'(n / 32), 2'b00, exp_pol, 1'b0, (n < PIXEL), 1'b1, 1'b0};
    bus_read(6'h30, d);
    checks++;
    if (d !== e) begin failures++; $display("FAIL %s status got=%h exp=%h", name, d, e); end
    checks++;
    if (user_interrupt !== 1'b1) begin failures++; $display("FAIL %s irq got=%b exp=1", name, user_interrupt); end
    for (int w = 0; w < NWORDS; w++) begin
      for (int b = 0; b < 32; b++) e[b] = model_buf[32*w + b];
      bus_read(6'(4*w), d);
      checks++;
      if (d !== e) begin failures++; $display("FAIL %s word%0d got=%h exp=%h", name, w, d, e); end
    end
    if (n == PIXEL) begin
      checks++;
      if (irq_off != cur_hoff + 2 + (PIXEL - 1) * (cur_div + 1)) begin
        failures++;
        $display("FAIL %s irq_offset got=%0d exp=%0d", name, irq_off, cur_hoff + 2 + (PIXEL - 1) * (cur_div + 1));
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    bus_read(6'h30, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", d); end
    bus_read(6'h34, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_line got=%h exp=0", d); end
    bus_read(6'h38, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_hoff got=%h exp=0", d); end
    bus_read(6'h3C, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_div got=%h exp=0", d); end
    checks++;
    if (user_interrupt !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", user_interrupt); end
    checks++;
    if (uo_out !== 8'h00 || bus_if.data_ready !== 1'b1) begin
      failures++; $display("FAIL reset_uo_ready got=%h/%b exp=00/1", uo_out, bus_if.data_ready);
    end
  endtask

  task automatic test_basic(input string name);
    logic [31:0] d;
    int act, n;
    setup(2, 5, 1);
    for (int o = 0; o < 4096; o++) line_pix[o] = 1'((((o + 1) / 2) % 2) == 0);
    act = full_len();
    capture_frame(act, 1'b0, -1);
    n = model_capture(act);
    check_capture(name, n);
    for (int w = 0; w < NWORDS; w++) begin
      bus_read(6'(4*w), d); checks++;
      if (d !== 32'h55555555) begin failures++; $display("FAIL %s pattern%0d got=%h exp=55555555", name, w, d); end
    end
    bus_read(6'h30, d); checks++;
    if (d !== (32'h00000A02 | 32'(exp_pol) << 4)) begin
      failures++; $display("FAIL %s status_const got=%h exp=%h", name, d, 32'h00000A02 | 32'(exp_pol) << 4);
    end
  endtask

  task automatic test_random_capture();
    int act, n;
    for (int k = 0; k < 4; k++) begin
      setup($urandom_range(0, 3), $urandom_range(0, 30), $urandom_range(0, 1));
      rand_pixels();
      act = full_len();
      capture_frame(act, 1'b0, -1);
      n = model_capture(act);
      check_capture("random", n);
    end
  endtask

  task automatic test_short_line();
    int act, n;
    setup($urandom_range(0, 2), $urandom_range(0, 20), 0);
    rand_pixels();
    act = cur_hoff + 2 + 100;
    capture_frame(act, 1'b0, -1);
    n = model_capture(act);
    check_capture("short100", n);
    setup($urandom_range(0, 2), $urandom_range(0, 20), $urandom_range(0, 1));
    rand_pixels();
    act = cur_hoff + 2 + int'($urandom_range(1, PIXEL - 40)) * (cur_div + 1);
    capture_frame(act, 1'b0, -1);
    n = model_capture(act);
    check_capture("short_rand", n);
  endtask

  task automatic test_abort_arm();
    logic [31:0] d;
    int act, n;
    setup(3, 4, 0);
    rand_pixels();
    bus_write(6'h30, 32'h1 | ctrl_pol);
    drive_vsync();
    drive_line(50, 1'b0, -1);
    bus_read(6'h30, d); checks++;
    if (d[0] !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%b exp=1", d[0]); end
    bus_write(6'h30, 32'h3 | ctrl_pol);
    bus_read(6'h30, d); checks++;
    if (d[2:0] !== 3'b000) begin failures++; $display("FAIL abort_status got=%b exp=000", d[2:0]); end
    for (int l = 0; l < 5; l++) drive_line(50, 1'b0, -1);
    bus_read(6'h30, d); checks++;
    if (d[2:0] !== 3'b000 || user_interrupt !== 1'b0) begin
      failures++; $display("FAIL abort_idle got=%b irq=%b exp=000 irq=0", d[2:0], user_interrupt);
    end
    act = full_len();
    capture_frame(act, 1'b0, -1);
    n = model_capture(act);
    check_capture("after_abort", n);
  endtask

  task automatic test_vsync_restart();
    int act, n;
    setup(3, $urandom_range(0, 10), 0);
    rand_pixels();
    act = full_len();
    capture_frame(act, 1'b1, -1);
    n = model_capture(act);
    check_capture("vsync_restart", n);
  endtask

  task automatic test_irq_ack_collision();
    logic [31:0] d;
    int act, n;
    setup(1, $urandom_range(0, 10), $urandom_range(0, 1));
    rand_pixels();
    act = full_len();
    capture_frame(act, 1'b0, cur_hoff + 2 + (PIXEL - 1) * (cur_div + 1));
    n = model_capture(act);
    check_capture("ack_collision", n);
    bus_write(6'h30, 32'h4 | ctrl_pol);
    checks++;
    if (user_interrupt !== 1'b0) begin failures++; $display("FAIL second_ack_irq got=%b exp=0", user_interrupt); end
    bus_read(6'h30, d); checks++;
    if (d[1] !== 1'b1) begin failures++; $display("FAIL ack_keeps_done got=%b exp=1", d[1]); end
  endtask

  task automatic test_sync_polarity();
    logic [31:0] d;
`ifdef VGA_CAPTURE_SYNC_POL_EN
    bus_write(6'h30, 32'h30);
    hpol = 1'b1; vpol = 1'b1;
    exp_pol = 2'b11; ctrl_pol = 32'h30;
    repeat (3) tick();
    test_basic("polarity_high");
    bus_write(6'h30, 32'h0);
    hpol = 1'b0; vpol = 1'b0;
    exp_pol = 2'b00; ctrl_pol = 32'h0;
    repeat (3) tick();
    bus_read(6'h30, d); checks++;
    if (d[5:4] !== 2'b00) begin failures++; $display("FAIL polarity_cleared got=%b exp=00", d[5:4]); end
`else
    bus_write(6'h30, 32'h30);
    bus_read(6'h30, d); checks++;
    if (d[5:4] !== 2'b00) begin failures++; $display("FAIL polarity_ignored got=%b exp=00", d[5:4]); end
`endif
  endtask

  task automatic test_rst_mid_sample();
    logic [31:0] d;
    setup(1, 3, 1);
    rand_pixels();
    bus_write(6'h30, 32'h1 | ctrl_pol);
    drive_vsync();
    drive_line(200, 1'b0, -1);
    drive_line(3 + 2 + 60, 1'b1, -1);
    bus_read(6'h30, d); checks++;
    if (d[0] !== 1'b1) begin failures++; $display("FAIL rst_mid_busy got=%b exp=1", d[0]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_read(6'h30, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL rst_mid_status got=%h exp=0", d); end
    checks++;
    if (user_interrupt !== 1'b0) begin failures++; $display("FAIL rst_mid_irq got=%b exp=0", user_interrupt); end
    bus_read(6'h34, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL rst_mid_line got=%h exp=0", d); end
    bus_read(6'h38, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL rst_mid_hoff got=%h exp=0", d); end
    bus_read(6'h3C, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL rst_mid_div got=%h exp=0", d); end
  endtask

  initial begin
    bus_if.address      = 6'h0;
    bus_if.data_in      = 32'h0;
    bus_if.data_write_n = 2'b11;
    bus_if.data_read_n  = 2'b11;
    test_reset();
    test_basic("basic");
    test_random_capture();
    test_short_line();
    test_abort_arm();
    test_vsync_restart();
    test_irq_ack_collision();
    test_sync_polarity();
    test_rst_mid_sample();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
